// File: rtl/awm_pkg.sv
// awm_pkg: shared constants, rule configuration type and edge-select helper
package awm_pkg;
  localparam int SIG_W = 14;
  localparam int MAX_DLY = 127;
  localparam int DLY_W = $clog2(MAX_DLY + 1);
  localparam int SEL_W = $clog2(SIG_W);
  localparam int FAIL_CNT_W = 16;
  typedef enum logic {EDGE_FALL = 1'b0, EDGE_RISE = 1'b1} edge_kind_e;
  typedef struct packed {
    logic en;
    logic [SEL_W-1:0] trig_sel;
    edge_kind_e trig_rise;
    logic [SEL_W-1:0] resp_sel;
    edge_kind_e resp_rise;
    logic [DLY_W-1:0] dly_min;
    logic [DLY_W-1:0] dly_max;
  } rule_cfg_t;
  function automatic logic edge_hit(input logic [SIG_W-1:0] rise, input logic [SIG_W-1:0] fall,
                                    input logic [SEL_W-1:0] sel, input edge_kind_e kind);
    return kind == EDGE_RISE ? rise[sel] : fall[sel];
  endfunction
endpackage

// File: rtl/awm_rule_engine.sv
// awm_rule_engine: one trigger->response window rule with per-age pending attempts
module awm_rule_engine
  import awm_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SIG_W-1:0] rise,
  input  logic [SIG_W-1:0] fall,
  input  logic             wr,
  input  logic             ld,
  input  rule_cfg_t        cfg_in,
  output logic             fail,
  output logic             busy
);
  rule_cfg_t cfg;
  logic [MAX_DLY:1] pend, pend_n, pend_clr, win, live, at_max;
  logic trig, resp, hit0;
  // age masks: ages kept alive, ages a response may satisfy, age that expires now
  always_comb begin
    win = '0;
    live = '0;
    at_max = '0;
    for (int k = 1; k <= MAX_DLY; k++) begin
      live[k] = k <= int'(cfg.dly_max);
      win[k] = live[k] && k >= int'(cfg.dly_min);
      at_max[k] = k == int'(cfg.dly_max);
    end
  end
  // a write to this rule drops the same-cycle trigger; a reload voids old attempts
  always_comb begin
    trig = cfg.en && !wr && edge_hit(rise, fall, cfg.trig_sel, cfg.trig_rise);
    resp = cfg.en && edge_hit(rise, fall, cfg.resp_sel, cfg.resp_rise);
    hit0 = resp && cfg.dly_min == '0;
    pend_clr = resp ? pend & ~win : pend;
    fail = cfg.en && !ld && (cfg.dly_max == '0 ? trig && !hit0 : |(pend_clr & at_max));
    pend_n = cfg.en ? {pend_clr[MAX_DLY-1:1], trig && !hit0} & live : '0;
  end
  // config load or attempt aging
  always_ff @(posedge clk)
    if (!rst_n) begin
      cfg <= '0;
      pend <= '0;
      busy <= 1'b0;
    end else if (ld) begin
      cfg <= cfg_in;
      pend <= '0;
      busy <= 1'b0;
    end else begin
      pend <= pend_n;
      busy <= |pend_n;
    end
endmodule

// File: rtl/assertion_window_monitor.sv
// assertion_window_monitor: programmable bounded-delay edge implication checker
module assertion_window_monitor
  import awm_pkg::*;
#(
  parameter int NUM_RULES = 20
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [SIG_W-1:0]             sig,
  input  logic                         cfg_we,
  input  logic [$clog2(NUM_RULES)-1:0] cfg_idx,
  input  logic                         cfg_en,
  input  logic [SEL_W-1:0]             cfg_trig_sel,
  input  logic [SEL_W-1:0]             cfg_resp_sel,
  input  logic                         cfg_trig_rise,
  input  logic                         cfg_resp_rise,
  input  logic [DLY_W-1:0]             cfg_dly_min,
  input  logic [DLY_W-1:0]             cfg_dly_max,
  input  logic                         clr_sticky,
  output logic [NUM_RULES-1:0]         fail_pulse,
  output logic [NUM_RULES-1:0]         fail_sticky,
  output logic [FAIL_CNT_W-1:0]        fail_cnt,
  output logic                         cfg_err,
  output logic [NUM_RULES-1:0]         busy
);
  logic [SIG_W-1:0] sig_q, rise, fall;
  logic sig_vld, legal;
  logic [NUM_RULES-1:0] fail;
  logic [FAIL_CNT_W:0] cnt_sum;
  rule_cfg_t new_cfg;
  // edges only once sig_q holds a real sample; config legality; next count
  always_comb begin
    rise = sig_vld ? sig & ~sig_q : '0;
    fall = sig_vld ? ~sig & sig_q : '0;
    legal = cfg_dly_min <= cfg_dly_max && int'(cfg_dly_max) <= MAX_DLY &&
            int'(cfg_trig_sel) < SIG_W && int'(cfg_resp_sel) < SIG_W && int'(cfg_idx) < NUM_RULES;
    new_cfg = '{en: cfg_en, trig_sel: cfg_trig_sel, trig_rise: edge_kind_e'(cfg_trig_rise),
                resp_sel: cfg_resp_sel, resp_rise: edge_kind_e'(cfg_resp_rise),
                dly_min: cfg_dly_min, dly_max: cfg_dly_max};
    cnt_sum = (clr_sticky ? '0 : {1'b0, fail_cnt}) + (FAIL_CNT_W + 1)'($countones(fail));
  end
  // previous-sample register for edge detection
  always_ff @(posedge clk)
    if (!rst_n) begin
      sig_q <= '0;
      sig_vld <= 1'b0;
    end else begin
      sig_q <= sig;
      sig_vld <= 1'b1;
    end
  // failure reporting; a new failure beats a same-cycle clear
  always_ff @(posedge clk)
    if (!rst_n) begin
      fail_pulse <= '0;
      fail_sticky <= '0;
      fail_cnt <= '0;
      cfg_err <= 1'b0;
    end else begin
      fail_pulse <= fail;
      fail_sticky <= (clr_sticky ? '0 : fail_sticky) | fail;
      fail_cnt <= cnt_sum[FAIL_CNT_W] ? '1 : cnt_sum[FAIL_CNT_W-1:0];
      if (cfg_we) cfg_err <= ~legal;
    end
  for (genvar i = 0; i < NUM_RULES; i++) begin : g_rule
    awm_rule_engine u_rule (
      .clk    (clk),
      .rst_n  (rst_n),
      .rise   (rise),
      .fall   (fall),
      .wr     (cfg_we && int'(cfg_idx) == i),
      .ld     (cfg_we && legal && int'(cfg_idx) == i),
      .cfg_in (new_cfg),
      .fail   (fail[i]),
      .busy   (busy[i])
    );
  end
endmodule

// File: tb/tb_assertion_window_monitor.sv
// tb_assertion_window_monitor: directed stimulus with queued expectations checked by a monitor
module tb_assertion_window_monitor;
  import awm_pkg::*;
  localparam int NR = 20;
  localparam int K_STICKY = 0, K_CNT = 1, K_ERR = 2, K_BUSY = 3;
  logic clk = 0, rst_n = 0, cfg_we = 0, cfg_en = 0, clr_sticky = 0;
  logic cfg_trig_rise = 0, cfg_resp_rise = 0;
  logic [SIG_W-1:0] sig = '0;
  logic [4:0] cfg_idx = '0;
  logic [SEL_W-1:0] cfg_trig_sel = '0, cfg_resp_sel = '0;
  logic [DLY_W-1:0] cfg_dly_min = '0, cfg_dly_max = '0;
  logic [NR-1:0] fail_pulse, fail_sticky, busy;
  logic [15:0] fail_cnt;
  logic cfg_err;
  int cyc = 0, n_cmp = 0, n_bad = 0;
  typedef struct {int cyc; logic [NR-1:0] pulse; logic [NR-1:0] sticky; logic [15:0] cnt;} pexp_t;
  typedef struct {int cyc; int kind; logic [31:0] val;} cexp_t;
  pexp_t pq[$];
  cexp_t cq[$];
  pexp_t pe;
  cexp_t ce;

  assertion_window_monitor #(.NUM_RULES(NR)) dut (
    .clk(clk), .rst_n(rst_n), .sig(sig), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en),
    .cfg_trig_sel(cfg_trig_sel), .cfg_resp_sel(cfg_resp_sel), .cfg_trig_rise(cfg_trig_rise),
    .cfg_resp_rise(cfg_resp_rise), .cfg_dly_min(cfg_dly_min), .cfg_dly_max(cfg_dly_max),
    .clr_sticky(clr_sticky), .fail_pulse(fail_pulse), .fail_sticky(fail_sticky),
    .fail_cnt(fail_cnt), .cfg_err(cfg_err), .busy(busy));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  function automatic string kname(input int k);
    return k == K_STICKY ? "sticky" : k == K_CNT ? "fail_cnt" : k == K_ERR ? "cfg_err" : "busy";
  endfunction

  function automatic logic [31:0] kval(input int k);
    return k == K_STICKY ? 32'(fail_sticky) : k == K_CNT ? 32'(fail_cnt) : k == K_ERR ? 32'(cfg_err) : 32'(busy);
  endfunction

  always @(negedge clk) begin
    while (pq.size() > 0 && pq[0].cyc < cyc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL missing_pulse @%0d: got none expected %h", pq[0].cyc, pq[0].pulse);
      void'(pq.pop_front());
    end
    if (fail_pulse != '0 || (pq.size() > 0 && pq[0].cyc == cyc)) begin
      if (pq.size() == 0 || pq[0].cyc != cyc) begin
        check("unexpected_pulse", 32'(fail_pulse), 32'h0);
      end else begin
        pe = pq.pop_front();
        check("pulse", 32'(fail_pulse), 32'(pe.pulse));
        check("pulse_sticky", 32'(fail_sticky), 32'(pe.sticky));
        check("pulse_cnt", 32'(fail_cnt), 32'(pe.cnt));
      end
    end
    while (cq.size() > 0 && cq[0].cyc <= cyc) begin
      ce = cq.pop_front();
      check(kname(ce.kind), kval(ce.kind), ce.val);
    end
  end

  function automatic void exp_pulse(input int t, input logic [NR-1:0] p, input logic [NR-1:0] s, input int c);
    pq.push_back('{t, p, s, 16'(c)});
  endfunction

  function automatic void exp_at(input int t, input int k, input logic [31:0] v);
    int p = cq.size();
    while (p > 0 && cq[p-1].cyc > t) p--;
    cq.insert(p, '{t, k, v});
  endfunction

  task automatic goto(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wcfg(input int idx, input bit en, input int ts, input bit tr, input int rs, input bit rr,
                      input int mn, input int mx);
    cfg_idx = 5'(idx);
    cfg_en = en;
    cfg_trig_sel = SEL_W'(ts);
    cfg_trig_rise = tr;
    cfg_resp_sel = SEL_W'(rs);
    cfg_resp_rise = rr;
    cfg_dly_min = DLY_W'(mn);
    cfg_dly_max = DLY_W'(mx);
    cfg_we = 1;
    @(posedge clk);
    #1;
    cfg_we = 0;
  endtask

  initial begin
    logic [NR-1:0] st_m, p;
    int cnt_m;
    exp_at(2, K_STICKY, 0);
    exp_at(2, K_CNT, 0);
    exp_at(2, K_ERR, 0);
    exp_at(2, K_BUSY, 0);
    goto(3); rst_n = 1;
    goto(5); wcfg(0, 1, 2, 1, 8, 1, 3, 5);
    exp_at(6, K_ERR, 0);
    exp_at(11, K_BUSY, 1);
    exp_at(15, K_BUSY, 0);
    goto(10); sig[2] = 1;
    goto(14); sig[8] = 1;
    goto(20); sig[2] = 0; sig[8] = 0;
    exp_pulse(31, 20'h1, 20'h1, 1);
    exp_at(31, K_BUSY, 0);
    goto(25); sig[2] = 1;
    goto(35); sig[2] = 0;
    goto(40); wcfg(0, 1, 2, 1, 8, 1, 2, 4);
    exp_at(50, K_BUSY, 0);
    goto(45); sig[2] = 1;
    goto(46); sig[2] = 0;
    goto(47); sig[2] = 1;
    goto(49); sig[8] = 1;
    goto(51); sig[2] = 0; sig[8] = 0;
    exp_at(60, K_BUSY, 1);
    exp_pulse(62, 20'h1, 20'h1, 2);
    exp_at(62, K_BUSY, 0);
    goto(55); sig[2] = 1;
    goto(56); sig[2] = 0;
    goto(57); sig[2] = 1;
    goto(58); sig[8] = 1;
    exp_at(66, K_STICKY, 0);
    exp_at(66, K_CNT, 0);
    goto(65); clr_sticky = 1;
    goto(66); clr_sticky = 0;
    goto(68); wcfg(1, 1, 5, 0, 5, 0, 0, 0);
    goto(70); sig[5] = 1;
    goto(72); sig[5] = 0;
    goto(73); wcfg(1, 1, 5, 0, 6, 1, 0, 0);
    exp_pulse(77, 20'h2, 20'h2, 1);
    goto(74); sig[5] = 1;
    goto(76); sig[5] = 0;
    goto(80); wcfg(2, 1, 3, 1, 4, 1, 21, 21);
    exp_pulse(107, 20'h4, 20'h6, 2);
    goto(85); sig[3] = 1;
    goto(105); sig[4] = 1;
    goto(110); sig[3] = 0; sig[4] = 0;
    exp_at(130, K_BUSY, 4);
    exp_at(134, K_BUSY, 0);
    goto(112); sig[3] = 1;
    goto(133); sig[4] = 1;
    goto(140); wcfg(2, 1, 3, 1, 4, 1, 9, 4);
    exp_at(141, K_ERR, 1);
    exp_at(145, K_ERR, 1);
    exp_at(145, K_BUSY, 4);
    exp_pulse(165, 20'h4, 20'h6, 3);
    goto(141); sig[3] = 0; sig[4] = 0;
    goto(143); sig[3] = 1;
    goto(167); sig[3] = 0;
    goto(170); sig[3] = 1;
    goto(175); wcfg(2, 1, 3, 1, 4, 1, 21, 21);
    exp_at(176, K_ERR, 0);
    exp_at(176, K_BUSY, 0);
    goto(180); wcfg(3, 1, 14, 1, 0, 1, 0, 1);
    exp_at(181, K_ERR, 1);
    exp_at(189, K_BUSY, 1);
    exp_at(190, K_STICKY, 0);
    exp_at(190, K_CNT, 0);
    exp_at(190, K_ERR, 0);
    exp_at(190, K_BUSY, 0);
    goto(185); sig[2] = 0;
    goto(188); sig[2] = 1;
    goto(189); rst_n = 0;
    goto(192); rst_n = 1;
    goto(195); wcfg(0, 1, 10, 1, 11, 1, 1, 3);
    wcfg(7, 1, 10, 1, 11, 1, 1, 3);
    wcfg(19, 1, 10, 1, 11, 1, 1, 3);
    exp_pulse(204, 20'h80081, 20'h80081, 3);
    exp_pulse(211, 20'h80081, 20'h80081, 3);
    goto(200); sig[10] = 1;
    goto(205); sig[10] = 0;
    goto(207); sig[10] = 1;
    goto(210); clr_sticky = 1;
    goto(211); clr_sticky = 0;
    exp_at(216, K_STICKY, 0);
    exp_at(216, K_CNT, 0);
    goto(215); clr_sticky = 1;
    goto(216); clr_sticky = 0;
    for (int i = 0; i < NR; i++) begin
      goto(220 + i);
      wcfg(i, 1, 12, i < 10, 13, 1, 0, 0);
    end
    goto(245);
    st_m = '0;
    cnt_m = 0;
    for (int n = 0; n < 6600; n++) begin
      sig[12] = ~sig[12];
      p = sig[12] ? 20'h003FF : 20'hFFC00;
      st_m |= p;
      cnt_m = cnt_m + 10 > 65535 ? 65535 : cnt_m + 10;
      exp_pulse(cyc + 1, p, st_m, cnt_m);
      @(posedge clk);
      #1;
    end
    goto(245 + 6600 + 10);
    n_cmp++;
    if (pq.size() != 0 || cq.size() != 0) begin
      n_bad++;
      $display("FAIL leftover_expectations: got %0d pending expected 0", pq.size() + cq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
